// File: rtl/nonce_search_controller_if.sv
// Hasher job bus between the nonce search controller (master) and the
// double-SHA256 hasher (slave). A job transfers on hash_start && hash_ready;
// hash_done strobes once with hash_result for the last accepted job.
interface nonce_search_controller_if;
   logic         hash_start;
   logic         hash_ready;
   logic [639:0] hash_header;
   logic         hash_done;
   logic [255:0] hash_result;

   modport master (
      output hash_start, hash_header,
      input  hash_ready, hash_done, hash_result
   );

   modport slave (
      input  hash_start, hash_header,
      output hash_ready, hash_done, hash_result
   );
endinterface

// File: rtl/nonce_search_controller.sv
// Nonce search controller: latches a block header received from uart_core,
// walks the 32-bit nonce field upward one hasher job at a time, and reports
// the first nonce whose hash has ZERO_BITS leading zero bits.
// Optional feature macro MINER_CONTINUE_SEARCH_EN: when defined, the search
// keeps going after a reported hit instead of returning to IDLE.
module nonce_search_controller #(
   parameter int ZERO_BITS = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [639:0]              header_data,
   input  logic                      header_valid,
   nonce_search_controller_if.master hash_bus,
   output logic [31:0]               found_nonce,
   output logic                      found_valid,
   output logic                      busy,
   output logic                      exhausted
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT, CHECK, REPORT, DRAIN, DONE
   } state_t;

   localparam logic [31:0]  LAST_NONCE = 32'hFFFF_FFFF;
   // Ones over the top ZERO_BITS bits of the hash; a hit has all of them clear.
   localparam logic [255:0] HIT_MASK   = ~({256{1'b1}} >> ZERO_BITS);

   state_t         state;
   logic [639:32]  header_q;
   logic [31:0]    nonce;
   logic [255:0]   result_q;
   logic           start_q;
   logic           hit;

   assign hash_bus.hash_start  = start_q;
   assign hash_bus.hash_header = {header_q, nonce};
   assign hit                  = ((result_q & HIT_MASK) == '0);

   // Search sequencer: header load, job issue/collect, hit check, reporting.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: all state uses non-blocking assignments so every register
         // samples the values of the previous cycle, whatever the statement order.
         state       <= IDLE;
         header_q    <= '0;
         nonce       <= '0;
         result_q    <= '0;
         start_q     <= 1'b0;
         found_nonce <= '0;
         found_valid <= 1'b0;
         busy        <= 1'b0;
         exhausted   <= 1'b0;
      end else begin
         // NOTE: default first, so found_valid is a one-cycle strobe unless a
         // branch below raises it again.
         found_valid <= 1'b0;

         // A new header always reloads the job template; the state decides
         // what happens to any work in flight.
         if (header_valid) begin
            header_q  <= header_data[639:32];
            nonce     <= header_data[31:0];
            exhausted <= 1'b0;
         end

         case (state)
            IDLE, DONE: begin
               if (header_valid) begin
                  state   <= ISSUE;
                  start_q <= 1'b1;
                  busy    <= 1'b1;
               end
            end

            ISSUE: begin
               // A job accepted in the same cycle as a new header is still
               // outstanding, so it has to be drained before the next issue.
               if (hash_bus.hash_ready) begin
                  start_q <= 1'b0;
                  state   <= header_valid ? DRAIN : WAIT;
               end
            end

            WAIT: begin
               if (header_valid) begin
                  // Same-cycle hash_done retires the old job: reissue at once.
                  state   <= hash_bus.hash_done ? ISSUE : DRAIN;
                  start_q <= hash_bus.hash_done;
               end else if (hash_bus.hash_done) begin
                  result_q <= hash_bus.hash_result;
                  state    <= CHECK;
               end
            end

            CHECK: begin
               if (header_valid) begin
                  state   <= ISSUE;
                  start_q <= 1'b1;
               end else if (hit) begin
                  found_valid <= 1'b1;
                  found_nonce <= nonce;
                  state       <= REPORT;
               end else if (nonce == LAST_NONCE) begin
                  exhausted <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end else begin
                  nonce   <= nonce + 32'd1;
                  start_q <= 1'b1;
                  state   <= ISSUE;
               end
            end

            REPORT: begin
               if (header_valid) begin
                  state   <= ISSUE;
                  start_q <= 1'b1;
               end else begin
`ifdef MINER_CONTINUE_SEARCH_EN
                  if (nonce == LAST_NONCE) begin
                     exhausted <= 1'b1;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end else begin
                     nonce   <= nonce + 32'd1;
                     start_q <= 1'b1;
                     state   <= ISSUE;
                  end
`else
                  busy  <= 1'b0;
                  state <= IDLE;
`endif
               end
            end

            DRAIN: begin
               // The discarded job's result never reaches CHECK.
               if (hash_bus.hash_done) begin
                  start_q <= 1'b1;
                  state   <= ISSUE;
               end
            end

            default: begin
               start_q <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_search_controller.sv
// Self-checking bench for nonce_search_controller: a table of hash results
// checked against ZERO_BITS=32 and ZERO_BITS=8 instances, plus hand-written
// multi-cycle sequences. Found reports are matched against a queue of
// expected nonces; accepted jobs are logged in a queue of transferred nonces.
module tb_nonce_search_controller;

`ifdef MINER_CONTINUE_SEARCH_EN
   localparam bit CONTINUE = 1'b1;
`else
   localparam bit CONTINUE = 1'b0;
`endif

   localparam logic [607:0] HDR_A = {19{32'hA5C3_0F01}};
   localparam logic [607:0] HDR_B = {19{32'h1234_5678}};
   localparam logic [255:0] MISS  = {256{1'b1}};
   localparam logic [255:0] HIT   = 256'h0;

   typedef struct {
      logic [255:0] result;
      logic         hit32;
      logic         hit8;
   } vec_t;

   logic         clock = 1'b0;
   logic         reset;
   logic [639:0] header_data;
   logic         header_valid;
   logic         hash_ready;
   logic         hash_done;
   logic [255:0] hash_result;

   logic [31:0]  found_nonce,  found_nonce8;
   logic         found_valid,  found_valid8;
   logic         busy,         busy8;
   logic         exhausted,    exhausted8;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] xfer_q[$];
   vec_t        vecs[9];

   nonce_search_controller_if bus ();
   nonce_search_controller_if bus8 ();

   assign bus.hash_ready   = hash_ready;
   assign bus.hash_done    = hash_done;
   assign bus.hash_result  = hash_result;
   assign bus8.hash_ready  = hash_ready;
   assign bus8.hash_done   = hash_done;
   assign bus8.hash_result = hash_result;

   nonce_search_controller #(.ZERO_BITS(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .header_data  (header_data),
      .header_valid (header_valid),
      .hash_bus     (bus.master),
      .found_nonce  (found_nonce),
      .found_valid  (found_valid),
      .busy         (busy),
      .exhausted    (exhausted)
   );

   nonce_search_controller #(.ZERO_BITS(8)) dut8 (
      .clock        (clock),
      .reset        (reset),
      .header_data  (header_data),
      .header_valid (header_valid),
      .hash_bus     (bus8.master),
      .found_nonce  (found_nonce8),
      .found_valid  (found_valid8),
      .busy         (busy8),
      .exhausted    (exhausted8)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: no job transfer within cycle budget", name);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      header_valid = 1'b0;
      header_data  = '0;
      hash_done    = 1'b0;
      hash_ready   = 1'b1;
      hash_result  = '0;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
      xfer_q.delete();
   endtask

   task automatic send_header(input logic [607:0] hi, input logic [31:0] n);
      header_data  = {hi, n};
      header_valid = 1'b1;
      tick();
      header_valid = 1'b0;
   endtask

   task automatic transfer(input string name);
      int n = 0;
      while (!(bus.hash_start && hash_ready) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeout_fail(name);
      tick();
   endtask

   task automatic complete(input logic [255:0] r);
      hash_result = r;
      hash_done   = 1'b1;
      tick();
      hash_done   = 1'b0;
   endtask

   task automatic serve(input string name, input logic [255:0] r);
      transfer(name);
      complete(r);
   endtask

   // Monitor: log accepted jobs and score found reports against expectations.
   always @(negedge clock) begin : monitor
      logic [31:0] e;
      if (!reset) begin
         if (bus.hash_start && bus.hash_ready) xfer_q.push_back(bus.hash_header[31:0]);
         if (found_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_found", 640'(found_valid), 640'(1'b0));
            end else begin
               e = exp_q.pop_front();
               check("found_nonce_sb", 640'(found_nonce), 640'(e));
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [31:0] n;

      vecs[0] = '{HIT,                      1'b1, 1'b1};
      vecs[1] = '{{32'h0, {224{1'b1}}},     1'b1, 1'b1};
      vecs[2] = '{{8'h00, {248{1'b1}}},     1'b0, 1'b1};
      vecs[3] = '{{8'h01, 248'h0},          1'b0, 1'b0};
      vecs[4] = '{(256'h1 << 224),          1'b0, 1'b1};
      vecs[5] = '{(256'h1 << 223),          1'b1, 1'b1};
      vecs[6] = '{MISS,                     1'b0, 1'b0};
      vecs[7] = '{(256'h1 << 248),          1'b0, 1'b0};
      vecs[8] = '{(256'h1 << 247),          1'b0, 1'b1};

      // Reset overrides a header strobe and a hash_done on the same edges.
      reset        = 1'b1;
      header_valid = 1'b1;
      header_data  = {HDR_A, 32'h9};
      hash_done    = 1'b1;
      hash_ready   = 1'b1;
      hash_result  = '0;
      tick();
      tick();
      check("rst_start",     640'(bus.hash_start), 640'(1'b0));
      check("rst_header",    bus.hash_header,      640'h0);
      check("rst_found_v",   640'(found_valid),    640'(1'b0));
      check("rst_found_n",   640'(found_nonce),    640'h0);
      check("rst_busy",      640'(busy),           640'(1'b0));
      check("rst_exhausted", 640'(exhausted),      640'(1'b0));
      check("rst_start8",    640'(bus8.hash_start), 640'(1'b0));

      // Table: one job per vector, outcome checked at M+2 on both widths.
      for (int i = 0; i < 9; i++) begin
         n = 32'h1000 + 32'(i);
         do_reset();
         send_header(HDR_A, n);
         transfer("tbl_xfer");
         if (vecs[i].hit32) exp_q.push_back(n);
         complete(vecs[i].result);
         check("tbl_no_early_found", 640'(found_valid), 640'(1'b0));
         tick();
         check("tbl_found32", 640'(found_valid),      640'(vecs[i].hit32));
         check("tbl_start32", 640'(bus.hash_start),   640'(!vecs[i].hit32));
         check("tbl_found8",  640'(found_valid8),     640'(vecs[i].hit8));
         check("tbl_start8",  640'(bus8.hash_start),  640'(!vecs[i].hit8));
         if (vecs[i].hit8)  check("tbl_nonce8",  640'(found_nonce8), 640'(n));
         if (!vecs[i].hit32) check("tbl_next32", 640'(bus.hash_header[31:0]), 640'(n + 32'd1));
         tick();
         check("tbl_busy_after", 640'(busy), 640'(vecs[i].hit32 ? CONTINUE : 1'b1));
      end

      // Three consecutive jobs from nonce 0x10, hit on 0x12.
      do_reset();
      send_header(HDR_A, 32'h10);
      check("seq_hdr_first", bus.hash_header, {HDR_A, 32'h10});
      serve("seq_j0", MISS);
      serve("seq_j1", MISS);
      transfer("seq_j2");
      exp_q.push_back(32'h12);
      complete(HIT);
      tick();
      check("seq_found_v", 640'(found_valid), 640'(1'b1));
      check("seq_found_n", 640'(found_nonce), 640'h12);
      check("seq_hdr_hit", bus.hash_header,   {HDR_A, 32'h12});
      tick();
      check("seq_strobe_once", 640'(found_valid), 640'(1'b0));
      check("seq_busy_end",    640'(busy),        640'(CONTINUE));
      check("seq_hold_nonce",  640'(found_nonce), 640'h12);
      check("seq_xfer_cnt",    640'(xfer_q.size() >= 3), 640'(1'b1));
      if (xfer_q.size() >= 3) begin
         check("seq_xfer0", 640'(xfer_q[0]), 640'h10);
         check("seq_xfer1", 640'(xfer_q[1]), 640'h11);
         check("seq_xfer2", 640'(xfer_q[2]), 640'h12);
      end

      // Exhaustion: 0xFFFFFFFE and 0xFFFFFFFF both miss.
      do_reset();
      send_header(HDR_A, 32'hFFFF_FFFE);
      serve("exh_j0", MISS);
      serve("exh_j1", MISS);
      tick();
      check("exh_flag",  640'(exhausted),      640'(1'b1));
      check("exh_busy",  640'(busy),           640'(1'b0));
      check("exh_start", 640'(bus.hash_start), 640'(1'b0));
      check("exh_jobs",  640'(xfer_q.size()),  640'd2);
      repeat (3) tick();
      check("exh_hold",  640'(exhausted),      640'(1'b1));
      check("exh_idle",  640'(bus.hash_start), 640'(1'b0));
      send_header(HDR_B, 32'h5);
      check("exh_clear",   640'(exhausted),      640'(1'b0));
      check("exh_restart", 640'(bus.hash_start), 640'(1'b1));
      check("exh_hdr",     bus.hash_header,      {HDR_B, 32'h5});

      // Hit on the last nonce is reported, not exhausted.
      do_reset();
      send_header(HDR_A, 32'hFFFF_FFFF);
      transfer("last_xfer");
      exp_q.push_back(32'hFFFF_FFFF);
      complete(HIT);
      tick();
      check("last_found_v", 640'(found_valid), 640'(1'b1));
      check("last_found_n", 640'(found_nonce), 640'hFFFF_FFFF);
      check("last_not_exh", 640'(exhausted),   640'(1'b0));
      tick();
      check("last_after_exh", 640'(exhausted), 640'(CONTINUE));

      // New headers during WAIT and DRAIN; the drained hit is discarded.
      do_reset();
      send_header(HDR_A, 32'h20);
      transfer("drn_xfer0");
      send_header(HDR_B, 32'h40);
      check("drn_busy",  640'(busy),           640'(1'b1));
      check("drn_start", 640'(bus.hash_start), 640'(1'b0));
      send_header(HDR_A, 32'h44);
      check("drn_stay",  640'(bus.hash_start), 640'(1'b0));
      complete(HIT);
      check("drn_reissue", 640'(bus.hash_start), 640'(1'b1));
      check("drn_hdr",     bus.hash_header,      {HDR_A, 32'h44});
      tick();
      tick();
      check("drn_no_found", 640'(found_valid),   640'(1'b0));
      check("drn_jobs",     640'(xfer_q.size()), 640'd2);
      if (xfer_q.size() == 2) check("drn_job_nonce", 640'(xfer_q[1]), 640'h44);

      // Header and hash_done together in WAIT: result dropped, new job issued.
      do_reset();
      send_header(HDR_A, 32'h50);
      transfer("both_xfer");
      header_data  = {HDR_B, 32'h60};
      header_valid = 1'b1;
      hash_result  = HIT;
      hash_done    = 1'b1;
      tick();
      header_valid = 1'b0;
      hash_done    = 1'b0;
      check("both_start", 640'(bus.hash_start), 640'(1'b1));
      check("both_hdr",   bus.hash_header,      {HDR_B, 32'h60});
      tick();
      tick();
      check("both_no_found", 640'(found_valid), 640'(1'b0));

      // Back-pressure: hash_ready low for five cycles.
      do_reset();
      hash_ready = 1'b0;
      send_header(HDR_A, 32'h70);
      for (int k = 0; k < 5; k++) begin
         check("bp_start", 640'(bus.hash_start), 640'(1'b1));
         check("bp_hdr",   bus.hash_header,      {HDR_A, 32'h70});
         tick();
      end
      hash_ready = 1'b1;
      tick();
      check("bp_start_drop", 640'(bus.hash_start), 640'(1'b0));
      check("bp_one_xfer",   640'(xfer_q.size()),  640'd1);
      tick();
      check("bp_still_one",  640'(xfer_q.size()),  640'd1);

      // Reset while a job is outstanding; its late hash_done is ignored.
      do_reset();
      send_header(HDR_A, 32'h80);
      transfer("rstw_xfer");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      xfer_q.delete();
      check("rstw_start", 640'(bus.hash_start), 640'(1'b0));
      check("rstw_hdr",   bus.hash_header,      640'h0);
      check("rstw_busy",  640'(busy),           640'(1'b0));
      complete(HIT);
      tick();
      tick();
      check("rstw_found_v", 640'(found_valid),    640'(1'b0));
      check("rstw_found_n", 640'(found_nonce),    640'h0);
      check("rstw_idle",    640'(bus.hash_start), 640'(1'b0));
      check("rstw_busy2",   640'(busy),           640'(1'b0));
      check("rstw_exh",     640'(exhausted),      640'(1'b0));
      check("rstw_no_job",  640'(xfer_q.size()),  640'd0);

      tick();
      check("sb_drained", 640'(exp_q.size()), 640'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nonce_search_controller.md
NONCE_SEARCH_CONTROLLER -- requirements
Module: nonce_search_controller

Interface
REQ-001 Parameter ZERO_BITS, default 32, range 1..256: count of leading zero bits hash_result[255:0] must have to count as a hit.
REQ-002 clock  input  1  system clock (the 50 MHz divided clock that also drives uart_core); single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 header_data  input  640  received block header; nonce field is header_data[31:0].
REQ-005 header_valid  input  1  one-cycle strobe from uart_core (rxce): header_data is complete and valid.
REQ-006 hash_ready  input  1  hasher can accept a job.
REQ-007 hash_start  output  1  job request; transfer occurs on a cycle with hash_start && hash_ready.
REQ-008 hash_header  output  640  latched header with current nonce in [31:0]; held stable while hash_start=1.
REQ-009 hash_done  input  1  one-cycle strobe: hash_result valid for the last accepted job.
REQ-010 hash_result  input  256  double-SHA256 result, bit 255 most significant.
REQ-011 found_nonce  output  32  winning nonce; feeds uart_core nonce_input.
REQ-012 found_valid  output  1  one-cycle strobe with found_nonce; drives uart_core transmit request.
REQ-013 busy  output  1  high in ISSUE, WAIT, CHECK, REPORT, DRAIN.
REQ-014 exhausted  output  1  level: nonce range finished with no hit.

Function
REQ-015 States: IDLE, ISSUE, WAIT, CHECK, REPORT, DRAIN, DONE.
REQ-016 IDLE/DONE: on header_valid latch header_data[639:32], nonce <= header_data[31:0], clear exhausted, go ISSUE; hash_start=1 the next cycle.
REQ-017 ISSUE: hash_start=1; on hash_ready go WAIT; hash_start deasserts the cycle after transfer; never more than one job outstanding.
REQ-018 WAIT: on hash_done register hash_result and go CHECK.
REQ-019 CHECK: hit = hash_result[255 -: ZERO_BITS] all zero; hit -> REPORT; no hit and nonce==32'hFFFFFFFF -> DONE with exhausted=1; else nonce <= nonce+1, go ISSUE.
REQ-020 Latency: hash_done at cycle M -> CHECK at M+1 -> found_valid=1 or hash_start=1 at M+2.
REQ-021 REPORT: found_valid=1 for exactly one cycle, found_nonce=nonce; found_nonce holds until next hit or reset.
REQ-022 Nonce never wraps; 32'hFFFFFFFF is the last nonce tried; a hit on it is reported (hit has priority over exhaustion).
REQ-023 header_valid in ISSUE/CHECK/REPORT: abandon current work, reload per REQ-016, go ISSUE; a pending REPORT strobe is still issued that cycle.
REQ-024 header_valid in WAIT: reload header/nonce, go DRAIN; DRAIN waits for hash_done, discards it, then ISSUE. header_valid in DRAIN reloads again, stays DRAIN.
REQ-025 header_valid and hash_done in same WAIT cycle: result discarded, go ISSUE with new header.
REQ-026 hash_done outside WAIT/DRAIN is ignored.

Reset
REQ-027 reset overrides all inputs; next edge: state IDLE, hash_start=0, hash_header=0, found_valid=0, found_nonce=0, busy=0, exhausted=0, nonce=0.
REQ-028 Reset mid-job drops the outstanding job; a later hash_done is ignored (state IDLE).

Configuration
REQ-029 Macro MINER_CONTINUE_SEARCH_EN defined: after REPORT, nonce==32'hFFFFFFFF -> DONE with exhausted=1, else nonce+1 and ISSUE; busy stays high.
REQ-030 MINER_CONTINUE_SEARCH_EN undefined: after REPORT go IDLE, busy=0, exhausted=0, wait for next header.

Verification
REQ-031 header_valid with nonce field 0x00000010, hasher always ready, result hits on nonce 0x12: hash_header[31:0] sequence 0x10,0x11,0x12; found_valid one cycle at M+2 with found_nonce=0x00000012.
REQ-032 Nonce field 0xFFFFFFFE, no hits: two jobs issued, then exhausted=1, busy=0, state DONE; new header_valid clears exhausted.
REQ-033 New header_valid while in WAIT: DRAIN; first hash_done discarded (found_valid stays 0 even if hit); next job carries new header's nonce.
REQ-034 hash_ready held low 5 cycles: hash_start and hash_header stable throughout; exactly one transfer.
REQ-035 reset asserted in WAIT, then hash_done: all outputs at reset values, no job issued, found_valid=0.
REQ-036 ZERO_BITS=8, result 0x00FF... : hit reported; result 0x01...: no hit.
